ram_bist_seq: RTL and testbench
===============================

# ram_bist_seq

Sequencer that drives the single-port block RAM directly, in place of the free-running read/write stimulus. On a start pulse it fills every location with a seeded pattern, reads every location back and compares each word against the expected value. The comparison accounts for the RAM's registered read latency. It reports done, pass/fail, the mismatch count and the first failing address to the top level.

## Interface
Parameters:
- ADDR_W, 5, RAM address width.
- DATA_W, 8, RAM data width.
- DEPTH, 32, number of locations tested, from address 0 to DEPTH-1. Must satisfy DEPTH ≤ 2^ADDR_W.
- RD_LAT, 1, RAM read latency in clocks. Legal values are 1 and 2.

Ports:
- clk, input, 1, system clock. All logic is rising-edge.
- rst_n, input, 1, asynchronous active-low reset. The block has one clock; reset is asynchronous and active-low.
- start, input, 1, single-cycle request to run a test. Ignored while busy is high.
- seed, input, DATA_W, pattern seed. Captured on an accepted start.
- ram_en, output, 1, RAM enable.
- ram_wr_H_rd_L, output, 1, write when 1, read when 0.
- ram_addr, output, ADDR_W, RAM address.
- ram_wr_data, output, DATA_W, RAM write data.
- ram_rd_data, input, DATA_W, RAM read data.
- busy, output, 1, high from the cycle after an accepted start until done.
- done, output, 1, one-cycle pulse when a run completes.
- pass, output, 1, result of the last completed run. Held until the next accepted start.
- err_cnt, output, ADDR_W+1, number of mismatches in the last run.
- first_err_addr, output, ADDR_W, address of the first mismatch. Stays 0 if there was none.

## Operation
- States: IDLE, WRITE, READ, DRAIN, DONE. All outputs are registered.
- Reset values:
  - State is IDLE.
  - ram_en, ram_wr_H_rd_L, ram_addr, ram_wr_data, busy, done, pass, err_cnt and first_err_addr are all 0.
- IDLE:
  - start=1 captures seed, clears err_cnt, first_err_addr and pass, then goes to WRITE with the address counter at 0.
- WRITE:
  - Drives ram_en=1, ram_wr_H_rd_L=1, ram_addr=a, ram_wr_data=(seed_q + a) mod 2^DATA_W.
  - a increments each cycle.
  - After address DEPTH-1 the block goes to READ with a=0.
- READ:
  - Drives ram_en=1, ram_wr_H_rd_L=0, ram_addr=a, and a increments each cycle.
  - Each issued read pushes {valid, addr, expected} into an RD_LAT-deep shift pipeline.
  - After address DEPTH-1 the block goes to DRAIN.
- DRAIN:
  - Drives ram_en=0 and ram_wr_H_rd_L=0.
  - Stays RD_LAT cycles so in-flight reads retire, then goes to DONE.
- Compare, active in READ and DRAIN:
  - When the pipeline tail is valid, ram_rd_data is compared with the tail's expected value.
  - On a mismatch, err_cnt increments.
  - If err_cnt was 0 at that mismatch, first_err_addr takes the tail address.
- DONE:
  - done=1 for one cycle.
  - pass = (err_cnt == 0), including any mismatch from the final compare.
  - busy goes to 0, and the next state is IDLE.
- Arithmetic:
  - The pattern add wraps modulo 2^DATA_W.
  - err_cnt cannot overflow, because the maximum is DEPTH ≤ 2^ADDR_W.
- start while busy: ignored, with no effect on the run.
- start in the DONE cycle: ignored. It is accepted only in IDLE.
- Reset mid-run:
  - All state returns to reset values immediately, and the shift pipeline is cleared.
  - The RAM contents are left partially written. That is acceptable.
- ram_en is 0 in IDLE, DRAIN and DONE, so the RAM is never accessed outside a run.

## Timing
- start is sampled high at edge k:
  - WRITE drives address 0 in cycle k+1 and address DEPTH-1 in cycle k+DEPTH.
  - READ occupies cycles k+DEPTH+1 through k+2·DEPTH.
  - DRAIN occupies cycles k+2·DEPTH+1 through k+2·DEPTH+RD_LAT.
  - done is high in cycle k+2·DEPTH+RD_LAT+1.
  - busy is high from cycle k+1 through k+2·DEPTH+RD_LAT, inclusive.
- With the defaults (DEPTH=32, RD_LAT=1), done appears 66 cycles after the start edge.
- Read data for an address issued in cycle c is compared at the end of cycle c+RD_LAT.
- There is no gap between the last write and the first read. A read-after-write to the same address is not required, because addresses restart at 0.
- Throughput is one access per cycle with no stalls. A new start is accepted at the earliest one cycle after done, which is IDLE.

## Test plan
- Defaults, RAM model with 1-cycle latency, seed=0x00, start pulse:
  - Location i holds i.
  - done arrives exactly 66 cycles after start.
  - pass=1, err_cnt=0, first_err_addr=0.
- seed=0xF0:
  - Location 0x0F holds 0xFF and location 0x10 holds 0x00, showing the pattern wrap.
  - pass=1.
- Fault injection: the model flips bit 3 on reads of addresses 5 and 20.
  - err_cnt=2, first_err_addr=5, pass=0.
- start re-asserted at cycles 10 and 40 of a run:
  - done timing and the result are unchanged.
  - A second start one cycle after done is accepted, with busy rising the next cycle.
- rst_n pulsed low during READ:
  - All outputs are 0 asynchronously, including done=0 and pass=0.
  - A fresh start then completes with pass=1.
- RD_LAT=2 with a 2-cycle RAM model:
  - done arrives 67 cycles after start and pass=1.
  - Fault injection at address 31 gives err_cnt=1 and first_err_addr=31. This proves the drain covers the last read.

Source files
------------

// File: rtl/ram_bist_seq.sv
// ram_bist_seq: march-free fill/readback self test for a single-port RAM.
// Writes seed+addr everywhere, reads it back and compares after RD_LAT.
module ram_bist_seq #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 8,
    parameter int DEPTH  = 32,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [DATA_W-1:0] seed,
    output logic              ram_en,
    output logic              ram_wr_H_rd_L,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wr_data,
    input  logic [DATA_W-1:0] ram_rd_data,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [ADDR_W:0]   err_cnt,
    output logic [ADDR_W-1:0] first_err_addr
);

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        READ,
        DRAIN,
        DONE
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(DEPTH - 1);
    localparam logic [1:0]        DRAIN_LAST = 2'(RD_LAT - 1);
    localparam logic [ADDR_W-1:0] ADDR_ONE   = ADDR_W'(1);
    localparam logic [ADDR_W:0]   CNT_ONE    = (ADDR_W + 1)'(1);

    state_t              state;
    logic [DATA_W-1:0]   seed_q;
    logic [1:0]          drain_cnt;
    logic [ADDR_W-1:0]   addr_nx;

    logic                pipe_v [RD_LAT];
    logic [ADDR_W-1:0]   pipe_a [RD_LAT];
    logic [DATA_W-1:0]   pipe_d [RD_LAT];

    logic                tail_v;
    logic [ADDR_W-1:0]   tail_a;
    logic [DATA_W-1:0]   tail_d;
    logic                cmp_act;
    logic                mismatch;

    // Tail of the in-flight read pipeline and the compare verdict.
    always_comb begin
        addr_nx  = ram_addr + ADDR_ONE;
        tail_v   = pipe_v[RD_LAT-1];
        tail_a   = pipe_a[RD_LAT-1];
        tail_d   = pipe_d[RD_LAT-1];
        cmp_act  = (state == READ) || (state == DRAIN);
        mismatch = cmp_act && tail_v && (ram_rd_data != tail_d);
    end

    // Shift each issued read through RD_LAT stages to line up with its data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < RD_LAT; i++) begin
                pipe_v[i] <= 1'b0;
                pipe_a[i] <= '0;
                pipe_d[i] <= '0;
            end
        end else begin
            pipe_v[0] <= (state == READ);
            pipe_a[0] <= ram_addr;
            pipe_d[0] <= seed_q + DATA_W'(ram_addr);
            for (int i = 1; i < RD_LAT; i++) begin
                pipe_v[i] <= pipe_v[i-1];
                pipe_a[i] <= pipe_a[i-1];
                pipe_d[i] <= pipe_d[i-1];
            end
        end
    end

    // Mismatch counting; the first failing address is latched once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt        <= '0;
            first_err_addr <= '0;
        end else if (state == IDLE && start) begin
            err_cnt        <= '0;
            first_err_addr <= '0;
        end else if (mismatch) begin
            err_cnt <= err_cnt + CNT_ONE;
            if (err_cnt == '0) begin
                first_err_addr <= tail_a;
            end
        end
    end

    // Sequencer: fill, read back, drain in-flight reads, report.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            seed_q        <= '0;
            drain_cnt     <= '0;
            ram_en        <= 1'b0;
            ram_wr_H_rd_L <= 1'b0;
            ram_addr      <= '0;
            ram_wr_data   <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            pass          <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        state         <= WRITE;
                        seed_q        <= seed;
                        pass          <= 1'b0;
                        busy          <= 1'b1;
                        ram_en        <= 1'b1;
                        ram_wr_H_rd_L <= 1'b1;
                        ram_addr      <= '0;
                        ram_wr_data   <= seed;
                    end
                end
                WRITE: begin
                    if (ram_addr == LAST_ADDR) begin
                        state         <= READ;
                        ram_wr_H_rd_L <= 1'b0;
                        ram_addr      <= '0;
                        ram_wr_data   <= '0;
                    end else begin
                        ram_addr    <= addr_nx;
                        ram_wr_data <= seed_q + DATA_W'(addr_nx);
                    end
                end
                READ: begin
                    if (ram_addr == LAST_ADDR) begin
                        state     <= DRAIN;
                        ram_en    <= 1'b0;
                        drain_cnt <= '0;
                    end else begin
                        ram_addr <= addr_nx;
                    end
                end
                DRAIN: begin
                    if (drain_cnt == DRAIN_LAST) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= (err_cnt == '0) && !mismatch;
                    end else begin
                        drain_cnt <= drain_cnt + 2'd1;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram_bist_seq.sv
// tb_ram_bist_seq: two sequencers (RD_LAT 1 and 2) on behavioural RAMs,
// checked cycle by cycle against a timeline model of a run.
module tb_ram_bist_seq;

    localparam int D = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]      start_s, en_s, wr_s, busy_s, done_s, pass_s;
    logic [1:0][7:0] seed_s, wd_s, rd_s;
    logic [1:0][4:0] addr_s, fea_s;
    logic [1:0][5:0] ec_s;

    logic [7:0]      mem [2][32];
    logic [1:0][7:0] q1, q2;
    logic [31:0]     fault [2];

    int checks = 0;
    int errors = 0;

    ram_bist_seq #(.RD_LAT(1)) u0 (
        .clk(clk), .rst_n(rst_n), .start(start_s[0]), .seed(seed_s[0]),
        .ram_en(en_s[0]), .ram_wr_H_rd_L(wr_s[0]), .ram_addr(addr_s[0]),
        .ram_wr_data(wd_s[0]), .ram_rd_data(rd_s[0]), .busy(busy_s[0]),
        .done(done_s[0]), .pass(pass_s[0]), .err_cnt(ec_s[0]),
        .first_err_addr(fea_s[0])
    );

    ram_bist_seq #(.RD_LAT(2)) u1 (
        .clk(clk), .rst_n(rst_n), .start(start_s[1]), .seed(seed_s[1]),
        .ram_en(en_s[1]), .ram_wr_H_rd_L(wr_s[1]), .ram_addr(addr_s[1]),
        .ram_wr_data(wd_s[1]), .ram_rd_data(rd_s[1]), .busy(busy_s[1]),
        .done(done_s[1]), .pass(pass_s[1]), .err_cnt(ec_s[1]),
        .first_err_addr(fea_s[1])
    );

    // Behavioural RAMs; reads of faulted addresses come back with bit 3 flipped.
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (en_s[i] && wr_s[i])
                mem[i][addr_s[i]] <= wd_s[i];
            if (en_s[i] && !wr_s[i])
                q1[i] <= mem[i][addr_s[i]] ^ (fault[i][addr_s[i]] ? 8'h08 : 8'h00);
            q2[i] <= q1[i];
        end
    end

    assign rd_s[0] = q1[0];
    assign rd_s[1] = q2[1];

    task automatic chk(input string name, input int unsigned act, input int unsigned exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got 0x%0h want 0x%0h", name, act, exp);
        end
    endtask

    // One run on instance i; called and returning at a falling edge while idle.
    task automatic run(input int i, input logic [7:0] sd, input logic [31:0] fm,
                       input bit glitch, output int done_t, output int e_cnt,
                       output int e_first);
        int lat;
        int t_end;
        int bad;
        lat     = (i == 0) ? 1 : 2;
        t_end   = 2 * D + lat + 1;
        e_cnt   = 0;
        e_first = 0;
        done_t  = -1;
        for (int j = 0; j < D; j++) begin
            if (fm[j]) begin
                if (e_cnt == 0) e_first = j;
                e_cnt++;
            end
        end
        fault[i]   = fm;
        seed_s[i]  = sd;
        start_s[i] = 1'b1;
        @(posedge clk);
        #1;
        start_s[i] = 1'b0;
        for (int t = 1; t <= t_end; t++) begin
            @(negedge clk);
            start_s[i] = glitch && (t == 10 || t == 40 || t == t_end);
            seed_s[i]  = 8'($urandom);
            if (done_s[i] && done_t < 0) done_t = t;
            chk("busy", busy_s[i], t < t_end);
            chk("done", done_s[i], t == t_end);
            chk("ram_en", en_s[i], t <= 2 * D);
            if (t <= 2 * D) begin
                chk("ram_wr", wr_s[i], t <= D);
                chk("ram_addr", addr_s[i], (t <= D) ? t - 1 : t - D - 1);
            end
            if (t <= D)
                chk("wr_data", wd_s[i], (sd + t - 1) & 8'hff);
            if (t < t_end) begin
                chk("pass_run", pass_s[i], 0);
            end else begin
                chk("pass", pass_s[i], e_cnt == 0);
                chk("err_cnt", ec_s[i], e_cnt);
                chk("first_err", fea_s[i], e_first);
            end
        end
        @(negedge clk);
        start_s[i] = 1'b0;
        chk("idle_busy", busy_s[i], 0);
        chk("idle_done", done_s[i], 0);
        chk("pass_hold", pass_s[i], e_cnt == 0);
        chk("idle_en", en_s[i], 0);
        bad = 0;
        for (int j = 0; j < D; j++)
            if (mem[i][j] !== 8'(sd + j)) bad++;
        chk("mem_pattern", bad, 0);
    endtask

    task automatic chk_zero(input int i);
        chk("rst_en", en_s[i], 0);
        chk("rst_wr", wr_s[i], 0);
        chk("rst_addr", addr_s[i], 0);
        chk("rst_wdata", wd_s[i], 0);
        chk("rst_busy", busy_s[i], 0);
        chk("rst_done", done_s[i], 0);
        chk("rst_pass", pass_s[i], 0);
        chk("rst_err", ec_s[i], 0);
        chk("rst_first", fea_s[i], 0);
    endtask

    initial begin
        int dt;
        int ec;
        int fe;
        int k;
        start_s  = '0;
        seed_s   = '0;
        fault[0] = '0;
        fault[1] = '0;
        repeat (3) @(negedge clk);
        chk_zero(0);
        chk_zero(1);
        rst_n = 1'b1;
        @(negedge clk);

        run(0, 8'h00, 32'h0, 1'b0, dt, ec, fe);
        chk("lat66", dt, 66);
        chk("lit_mem7", mem[0][7], 8'h07);
        chk("lit_pass0", pass_s[0], 1);

        run(0, 8'hF0, 32'h0, 1'b0, dt, ec, fe);
        chk("lit_wrap_0f", mem[0][15], 8'hFF);
        chk("lit_wrap_10", mem[0][16], 8'h00);

        run(0, 8'($urandom), 32'h0010_0020, 1'b0, dt, ec, fe);
        chk("lit_err2", ec_s[0], 2);
        chk("lit_first5", fea_s[0], 5);
        chk("lit_fail", pass_s[0], 0);

        run(0, 8'($urandom), 32'h0, 1'b1, dt, ec, fe);
        chk("glitch_lat", dt, 66);

        run(0, 8'($urandom), 32'h0, 1'b0, dt, ec, fe);
        seed_s[0]  = 8'($urandom);
        start_s[0] = 1'b1;
        @(posedge clk);
        #1;
        start_s[0] = 1'b0;
        repeat (D + 5) @(negedge clk);
        chk("pre_rst_read", en_s[0] && !wr_s[0], 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_zero(0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run(0, 8'($urandom), 32'h0, 1'b0, dt, ec, fe);
        chk("post_rst_pass", pass_s[0], 1);

        run(1, 8'($urandom), 32'h0, 1'b0, dt, ec, fe);
        chk("lat67", dt, 67);
        chk("lit_pass2", pass_s[1], 1);
        run(1, 8'($urandom), 32'h8000_0000, 1'b0, dt, ec, fe);
        chk("lit_err31", ec_s[1], 1);
        chk("lit_first31", fea_s[1], 31);

        for (int n = 0; n < 8; n++) begin
            k = int'($urandom_range(0, 1));
            run(k, 8'($urandom), $urandom & $urandom & $urandom,
                1'($urandom), dt, ec, fe);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
